// File: rtl/twiddle_fetch_seq_if.sv
// Command, twiddle-ROM read and twiddle-stream signals of twiddle_fetch_seq.
// The sequencer takes the master modport; controller, ROM and consumer share the slave modport.
interface twiddle_fetch_seq_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] tw_data;
  logic              tw_valid;
  logic              tw_ready;
  logic              tw_last;
  logic [CNT_W-1:0]  tw_index;

  modport master (
    input  start, base_addr, count, rom_data, tw_ready,
    output busy, done, rom_addr, rom_rd, tw_data, tw_valid, tw_last, tw_index
  );

  modport slave (
    output start, base_addr, count, rom_data, tw_ready,
    input  busy, done, rom_addr, rom_rd, tw_data, tw_valid, tw_last, tw_index
  );
endinterface

// File: rtl/twiddle_fetch_seq.sv
// Walks a run of twiddle ROM addresses and streams the words over valid/ready,
// hiding the one-clock ROM latency behind a 2-entry skid buffer.
module twiddle_fetch_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 28,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  twiddle_fetch_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;

  logic              ret_q;
  logic [CNT_W-1:0]  ret_idx_q;
  logic              ret_last_q;

  logic [DATA_W-1:0] skid_data_q [2];
  logic [CNT_W-1:0]  skid_idx_q  [2];
  logic              skid_last_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        occ_q;

  logic              push;
  logic              pop;
  logic [1:0]        credit_use;
  logic              issue;
  logic              last_issue;
  logic [ADDR_W-1:0] addr_next;

  // Credit counts the entries left after this cycle's pop plus the word returning
  // from the ROM now, so a steady ready=1 consumer still gets one word per cycle.
  always_comb begin
    pop        = (occ_q != 2'd0) && bus.tw_ready;
    push       = ret_q;
    credit_use = occ_q - {1'b0, pop} + {1'b0, ret_q};
    issue      = (state_q == RUN) && (credit_use < 2'd2);
    last_issue = issue && (issue_cnt_q == count_q - CNT_W'(1));
    addr_next  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = pop ? accept_cnt_q + CNT_W'(1) : accept_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            count_d      = bus.count;
            addr_d       = bus.base_addr;
            issue_cnt_d  = '0;
            accept_cnt_d = '0;
            state_d      = RUN;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          // Holding the address on the final read keeps rom_addr at the last word fetched.
          if (last_issue) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_next;
          end
        end
      end
      DRAIN: begin
        if (pop && (accept_cnt_q == count_q - CNT_W'(1))) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      ret_q        <= 1'b0;
      ret_idx_q    <= '0;
      ret_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      ret_q        <= issue;
      ret_idx_q    <= issue_cnt_q;
      ret_last_q   <= last_issue;
    end
  end

  // The returning ROM word is tagged with the index and last flag captured at issue time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        skid_data_q[i] <= '0;
        skid_idx_q[i]  <= '0;
        skid_last_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        skid_data_q[wr_ptr_q] <= bus.rom_data;
        skid_idx_q[wr_ptr_q]  <= ret_idx_q;
        skid_last_q[wr_ptr_q] <= ret_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.busy     = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done     = (state_q == FIN);
  assign bus.rom_rd   = issue;
  assign bus.rom_addr = addr_q;
  assign bus.tw_valid = (occ_q != 2'd0);
  assign bus.tw_data  = skid_data_q[rd_ptr_q];
  assign bus.tw_index = skid_idx_q[rd_ptr_q];
  assign bus.tw_last  = skid_last_q[rd_ptr_q];

endmodule

// File: doc/twiddle_fetch_seq.md
Name: twiddle_fetch_seq

Overview:
- Read-side sequencer for the synchronous twiddle ROMs: on a start command it walks a run of ROM addresses and returns the twiddle words over a valid/ready stream.
- Sits between the CWT/FFT stage controller and a twiddle ROM (5-bit address, 16-bit Q8.8 word, one-clock registered read).
- Absorbs the ROM read latency with a 2-entry skid buffer, so consumer backpressure never loses or duplicates a word.

Parameters:
ADDR_W, 5, ROM address width
DATA_W, 16, twiddle word width (signed Q8.8)
DEPTH, 28, populated ROM entries; address walk wraps modulo DEPTH
CNT_W, 6, width of the count input (max run length 2^CNT_W-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; ignored while busy=1
base_addr  in  ADDR_W  first ROM address of the run; sampled on start; must be < DEPTH
count  in  CNT_W  number of words in the run; sampled on start
busy  out  1  high from the cycle after an accepted start until the cycle done pulses
done  out  1  one-cycle pulse after the last word is accepted, or after a zero-count start
rom_addr  out  ADDR_W  registered address to the ROM
rom_data  in  DATA_W  ROM output; valid the cycle after rom_addr was presented with rom_rd=1
rom_rd  out  1  high in each cycle whose rom_addr is a real read
tw_data  out  DATA_W  twiddle word
tw_valid  out  1  tw_data valid
tw_ready  in  1  consumer accepts when tw_valid and tw_ready are both 1
tw_last  out  1  marks the final word of the run
tw_index  out  CNT_W  0-based position of tw_data within the run

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, rom_rd=0, rom_addr=0, tw_valid=0, tw_last=0, tw_index=0, tw_data=0. Skid buffer and in-flight flag are cleared. Reset mid-run abandons the run with no done pulse.
- States:
  - IDLE: start with count>0 loads base_addr and count, clears the issue and accept counters, goes to RUN, busy=1 next cycle. Start with count=0 goes to FIN.
  - RUN: issues reads. After the last read is issued, goes to DRAIN.
  - DRAIN: waits until all count words are accepted, then goes to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, returns to IDLE. A start in FIN is ignored.
- Issue rule: in RUN a read is issued only when (skid occupancy + in-flight) < 2.
  - On issue: rom_rd=1 and rom_addr=current address for that cycle.
  - The next address is (addr+1 == DEPTH) ? 0 : addr+1.
- ROM latency: a read issued with rom_addr in cycle t returns rom_data in cycle t+1. That word is written into the skid buffer at the end of cycle t+1.
- Skid buffer: 2-entry FIFO. tw_data, tw_index and tw_last come from the head entry.
  - tw_valid = not empty.
  - Pop on tw_valid & tw_ready.
  - Push and pop in the same cycle are both allowed.
  - The credit rule above makes overflow impossible.
- Throughput: with tw_ready held high, one word per cycle. First tw_valid appears 3 cycles after the start cycle (start→RUN, issue, ROM return, buffer).
- tw_last=1 only on the entry with tw_index == count-1.
- Outputs hold stable while tw_valid=1 and tw_ready=0.
- rom_rd=0 outside issue cycles. rom_addr holds its last value.
- count=1: one word, tw_last set on it, index 0.
- Wrap: base_addr=26, count=4 reads addresses 26, 27, 0, 1.
- tw_ready asserted while tw_valid=0 has no effect.

Test Plan:
1. base_addr=12, count=4, tw_ready=1 → 4 consecutive beats 0x0100, 0x00EC, 0x00B5, 0x0061; tw_index 0..3; tw_last on the 4th; done one cycle after the 4th beat.
2. base_addr=9, count=3, tw_ready toggling 1,0,0,1,0,1… → accepted words exactly 0x00B5, 0x0000, 0xFF4A in order, no duplicates; tw_data stable while stalled; rom_rd never issued with more than 2 outstanding.
3. base_addr=26, count=4 → rom_addr sequence 26, 27, 0, 1; data 0xFF87, 0xFF7C, 0x0100, 0x0100.
4. count=0 start → done pulses next cycle, busy stays 0, no rom_rd, no tw_valid.
5. Start pulse while busy (base_addr=0, count=5 run in progress) → second start ignored; exactly 5 words delivered.
6. rst_n low after 2 of 6 words accepted → all outputs return to their reset values asynchronously, no done pulse. A fresh run after reset (base_addr=20, count=2) yields 0x00B5, 0x00A2.
